shift_sub_divider: RTL and testbench

SHIFT_SUB_DIVIDER -- requirements
Module: shift_sub_divider

---
 rtl/shift_sub_divider_pkg.sv | 14 +
 rtl/shift_sub_divider_trial_subtractor.sv | 21 ++
 rtl/shift_sub_divider.sv | 122 ++++++++++++
 tb/tb_shift_sub_divider.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift/subtract divider: FSM state encoding
// and the default operand width.
package shift_sub_divider_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/shift_sub_divider_trial_subtractor.sv
// One restoring-division step: subtract the divisor from the shifted
// partial remainder and report whether the subtraction borrowed.
module trial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   partial,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] trial;

    // Full-width subtraction; the top bit is the borrow out.
    always_comb begin
        trial  = partial - {1'b0, divisor};
        diff   = trial[WIDTH-1:0];
        borrow = trial[WIDTH];
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider, one quotient bit per clock.
//
// Handshake: Run is a level request; a run starts only on a rising edge of
// Run seen in IDLE (and only after Run has been observed low since reset).
// Done acts as the result-valid flag and stays high, with Qval/Rval/Div_Zero
// stable, until Run is dropped (acknowledge) or a new dividend is loaded.
// Load_Dividend and Run are ignored while Busy.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] S,
    input  logic             Load_Dividend,
    input  logic             Run,
    output logic [WIDTH-1:0] Qval,
    output logic [WIDTH-1:0] Rval,
    output logic             Busy,
    output logic             Done,
    output logic             Div_Zero,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] cnt;
    logic             run_q;
    logic             run_armed;
    logic             run_start;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_borrow;

    trial_subtractor #(.WIDTH(WIDTH)) u_trial (
        .partial (({Rval, Qval[WIDTH-1]})),
        .divisor (d_reg),
        .diff    (trial_diff),
        .borrow  (trial_borrow)
    );

    // A start needs a fresh rising edge of Run, and Run must have been
    // seen low at least once since reset so a stuck-high Run cannot start.
    assign run_start = Run & ~run_q & run_armed;

    assign dbg_state = state;

    // Main FSM: operand registers, iteration counter and registered status.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Qval      <= '0;
            Rval      <= '0;
            d_reg     <= '0;
            cnt       <= '0;
            run_q     <= 1'b0;
            run_armed <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Div_Zero  <= 1'b0;
        end else begin
            run_q <= Run;
            if (!Run) begin
                run_armed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (Load_Dividend) begin
                        Qval     <= S;
                        Rval     <= '0;
                        Div_Zero <= 1'b0;
                    end else if (run_start) begin
                        state <= LOAD;
                        Busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    d_reg    <= S;
                    Rval     <= '0;
                    cnt      <= '0;
                    Div_Zero <= (S == '0);
                    state    <= ITER;
                end
                ITER: begin
                    Qval <= {Qval[WIDTH-2:0], ~trial_borrow};
                    if (trial_borrow) begin
                        Rval <= {Rval[WIDTH-2:0], Qval[WIDTH-1]};
                    end else begin
                        Rval <= trial_diff;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (Load_Dividend) begin
                        Qval     <= S;
                        Rval     <= '0;
                        Div_Zero <= 1'b0;
                        state    <= IDLE;
                        Done     <= 1'b0;
                    end else if (!Run) begin
                        state <= IDLE;
                        Done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed-vector bench for shift_sub_divider.
module tb_shift_sub_divider;

    logic       Clk;
    logic       Reset_n;
    logic [7:0] S;
    logic       Load_Dividend;
    logic       Run;
    logic [7:0] Qval;
    logic [7:0] Rval;
    logic       Busy;
    logic       Done;
    logic       Div_Zero;
    logic [1:0] dbg_state;

    int checks;
    int errors;
    logic overlap_seen;
    logic [15:0] exp_q[$];

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    shift_sub_divider #(.WIDTH(8)) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .S             (S),
        .Load_Dividend (Load_Dividend),
        .Run           (Run),
        .Qval          (Qval),
        .Rval          (Rval),
        .Busy          (Busy),
        .Done          (Done),
        .Div_Zero      (Div_Zero),
        .dbg_state     (dbg_state)
    );

    // Clock / reset block
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Busy and Done must never be high together.
    always @(negedge Clk) begin
        if (Reset_n && Busy && Done) overlap_seen = 1'b1;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] v);
        Load_Dividend = 1'b1;
        S = v;
        tick();
        Load_Dividend = 1'b0;
    endtask

    // Start a run with divisor dv; returns the number of edges until Done
    // (bounded at 20). Run is released afterwards and one edge is taken.
    task automatic run_div(input logic [7:0] dv, output int edges);
        Run = 1'b1;
        S = dv;
        edges = 0;
        while (!Done && edges < 20) begin
            tick();
            edges++;
        end
        Run = 1'b0;
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset_n = 1'b0;
        Run = 1'b0;
        Load_Dividend = 1'b0;
        S = 8'h00;
        tick();
        tick();
        checks++;
        if ({Qval, Rval} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_qr: got %h/%h want 00/00", Qval, Rval);
        end
        checks++;
        if ({Busy, Done, Div_Zero, dbg_state} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_flags: got busy=%b done=%b dz=%b st=%0d want all 0",
                     Busy, Done, Div_Zero, dbg_state);
        end
        Reset_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int e;
        logic [15:0] exp;
        do_load(8'hC8);
        checks++;
        if (Qval !== 8'hC8 || Rval !== 8'h00) begin
            errors++;
            $display("FAIL load_200: got %h/%h want c8/00", Qval, Rval);
        end
        exp_q.push_back(16'h1C04);
        run_div(8'd7, e);
        checks++;
        if (e !== 10) begin
            errors++;
            $display("FAIL latency: got %0d edges want 10", e);
        end
        exp = exp_q.pop_front();
        checks++;
        if ({Qval, Rval} !== exp) begin
            errors++;
            $display("FAIL div_200_7: got %h want %h", {Qval, Rval}, exp);
        end
        checks++;
        if (Div_Zero !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL div_200_7_flags: got dz=%b st=%0d want 0/0", Div_Zero, dbg_state);
        end
    endtask

    task automatic test_chained();
        int e;
        logic [15:0] exp;
        exp_q.push_back(16'h0400);
        run_div(8'd7, e);
        exp = exp_q.pop_front();
        checks++;
        if ({Qval, Rval} !== exp || e !== 10) begin
            errors++;
            $display("FAIL chained_28_7: got %h after %0d edges want %h after 10", {Qval, Rval}, e, exp);
        end
    endtask

    task automatic test_boundary();
        int e;
        logic [15:0] exp;
        do_load(8'hFF);
        exp_q.push_back(16'hFF00);
        run_div(8'd1, e);
        exp = exp_q.pop_front();
        checks++;
        if ({Qval, Rval} !== exp) begin
            errors++;
            $display("FAIL div_255_1: got %h want %h", {Qval, Rval}, exp);
        end
        do_load(8'h05);
        exp_q.push_back(16'h0005);
        run_div(8'd9, e);
        exp = exp_q.pop_front();
        checks++;
        if ({Qval, Rval} !== exp) begin
            errors++;
            $display("FAIL div_5_9: got %h want %h", {Qval, Rval}, exp);
        end
    endtask

    task automatic test_div_zero();
        int e;
        do_load(8'h64);
        run_div(8'd0, e);
        checks++;
        if (Qval !== 8'hFF || Rval !== 8'h64 || Div_Zero !== 1'b1) begin
            errors++;
            $display("FAIL div_zero: got %h/%h dz=%b want ff/64 dz=1", Qval, Rval, Div_Zero);
        end
        do_load(8'h10);
        checks++;
        if (Div_Zero !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_clear: got dz=%b want 0", Div_Zero);
        end
    endtask

    task automatic test_reset_mid_iter();
        int e;
        do_load(8'hC8);
        Run = 1'b1;
        S = 8'd7;
        repeat (5) tick();
        checks++;
        if (dbg_state !== ST_ITER || Busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_iter_state: got st=%0d busy=%b want 2/1", dbg_state, Busy);
        end
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({Qval, Rval, Busy, Done, Div_Zero, dbg_state} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset: got q=%h r=%h busy=%b done=%b dz=%b st=%0d want all 0",
                     Qval, Rval, Busy, Done, Div_Zero, dbg_state);
        end
        Run = 1'b0;
        #2;
        Reset_n = 1'b1;
        tick();
        do_load(8'hC8);
        run_div(8'd7, e);
        checks++;
        if ({Qval, Rval} !== 16'h1C04 || e !== 10) begin
            errors++;
            $display("FAIL after_reset_run: got %h after %0d edges want 1c04 after 10", {Qval, Rval}, e);
        end
    endtask

    task automatic test_ignore_busy();
        int e;
        do_load(8'hC8);
        Run = 1'b1;
        S = 8'd7;
        e = 0;
        while (!Done && e < 20) begin
            tick();
            e++;
            if (e >= 2 && e < 8) begin
                S = 8'h33;
                Load_Dividend = e[0];
            end else begin
                Load_Dividend = 1'b0;
            end
        end
        Load_Dividend = 1'b0;
        checks++;
        if (e !== 10 || {Qval, Rval} !== 16'h1C04) begin
            errors++;
            $display("FAIL load_during_iter: got %h after %0d edges want 1c04 after 10", {Qval, Rval}, e);
        end
        repeat (3) tick();
        checks++;
        if (Done !== 1'b1 || Busy !== 1'b0 || dbg_state !== ST_DONE || {Qval, Rval} !== 16'h1C04) begin
            errors++;
            $display("FAIL run_held_done: got done=%b busy=%b st=%0d qr=%h want 1/0/3/1c04",
                     Done, Busy, dbg_state, {Qval, Rval});
        end
        Run = 1'b0;
        tick();
        checks++;
        if (dbg_state !== ST_IDLE || Done !== 1'b0 || {Qval, Rval} !== 16'h1C04) begin
            errors++;
            $display("FAIL done_to_idle: got st=%0d done=%b qr=%h want 0/0/1c04", dbg_state, Done, {Qval, Rval});
        end
    endtask

    task automatic test_load_in_done();
        int e;
        do_load(8'h0E);
        Run = 1'b1;
        S = 8'd2;
        e = 0;
        while (!Done && e < 20) begin
            tick();
            e++;
        end
        checks++;
        if ({Qval, Rval} !== 16'h0700) begin
            errors++;
            $display("FAIL div_14_2: got %h want 0700", {Qval, Rval});
        end
        do_load(8'h2A);
        checks++;
        if (dbg_state !== ST_IDLE || Qval !== 8'h2A || Rval !== 8'h00 || Done !== 1'b0) begin
            errors++;
            $display("FAIL load_in_done: got st=%0d q=%h r=%h done=%b want 0/2a/00/0", dbg_state, Qval, Rval, Done);
        end
        repeat (3) tick();
        checks++;
        if (Busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL held_run_no_restart: got busy=%b st=%0d want 0/0", Busy, dbg_state);
        end
        Run = 1'b0;
        tick();
    endtask

    task automatic test_run_high_at_reset();
        int e;
        Run = 1'b1;
        Reset_n = 1'b0;
        #3;
        Reset_n = 1'b1;
        repeat (4) tick();
        checks++;
        if (Busy !== 1'b0 || dbg_state !== ST_IDLE) begin
            errors++;
            $display("FAIL run_high_reset: got busy=%b st=%0d want 0/0", Busy, dbg_state);
        end
        Run = 1'b0;
        do_load(8'hC8);
        run_div(8'd7, e);
        checks++;
        if ({Qval, Rval} !== 16'h1C04 || e !== 10) begin
            errors++;
            $display("FAIL rearm_run: got %h after %0d edges want 1c04 after 10", {Qval, Rval}, e);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap_seen !== 1'b0) begin
            errors++;
            $display("FAIL busy_done_overlap: got %b want 0", overlap_seen);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        overlap_seen = 1'b0;
        test_reset();
        test_basic();
        test_chained();
        test_boundary();
        test_div_zero();
        test_reset_mid_iter();
        test_ignore_busy();
        test_load_in_done();
        test_run_high_at_reset();
        test_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
